mmm_exp_ctrl: RTL and testbench



---
 rtl/mmm_exp_pkg.sv | 29 ++
 rtl/mmm_phase_gen.sv | 74 +++++++
 rtl/mmm_exp_ctrl.sv | 153 +++++++++++++++
 tb/tb_mmm_exp_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mmm_exp_pkg.sv
// mmm_exp_pkg: shared types and constants for the modular-exponentiation
// sequencer (mmm_exp_ctrl) and its phase generator (mmm_phase_gen).
//   exp_state_t          : sequencer state encoding
//   PH_*                 : phase offsets within one multiplier operation
//   op_len(width)        : cycles per multiplier operation
package mmm_exp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQR,
    ST_MUL,
    ST_CONV,
    ST_FIN
  } exp_state_t;

  // Absolute phases at the start of an op
  localparam int PH_CLEAR = 0;
  localparam int PH_LD_A  = 1;
  localparam int PH_RUN   = 2;
  // Phases at the end of an op, expressed as offsets from WIDTH
  localparam int PH_LAST_RUN_OFS = 1;
  localparam int PH_LD_R_OFS     = 2;
  localparam int PH_LOCK_OFS     = 3;

  function automatic int op_len(input int width);
    return width + 4;
  endfunction

endpackage

// File: rtl/mmm_phase_gen.sv
// mmm_phase_gen: per-operation phase counter and multiplier strobe decode.
// Ports:
//   clk, rstb        clock, async active-low reset
//   ena              global enable; low freezes counter and strobes
//   op_start         begin a new op in the next cycle (p=0)
//   mmm_clear/ld_a/ld_r/lock  registered strobes for the multiplier
//   op_last          high in the lock cycle (final phase of an op)
module mmm_phase_gen
  import mmm_exp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  input  logic op_start,
  output logic mmm_clear,
  output logic mmm_ld_a,
  output logic mmm_ld_r,
  output logic mmm_lock,
  output logic op_last
);

  localparam int OPL = op_len(WIDTH);
  localparam int PW  = $clog2(OPL);

  localparam logic [PW-1:0] P_CLEAR = PW'(PH_CLEAR);
  localparam logic [PW-1:0] P_LD_A  = PW'(PH_LD_A);
  localparam logic [PW-1:0] P_LD_R  = PW'(WIDTH + PH_LD_R_OFS);
  localparam logic [PW-1:0] P_LOCK  = PW'(WIDTH + PH_LOCK_OFS);

  logic [PW-1:0] p_q, p_nxt;
  logic          act_q, act_nxt;

  // A new op may start in the same cycle the previous one locks; without
  // op_start the counter parks at 0 and goes inactive after the lock phase.
  always_comb begin
    p_nxt   = p_q;
    act_nxt = act_q;
    if (op_start) begin
      p_nxt   = P_CLEAR;
      act_nxt = 1'b1;
    end else if (act_q) begin
      if (p_q == P_LOCK) begin
        p_nxt   = '0;
        act_nxt = 1'b0;
      end else begin
        p_nxt = p_q + PW'(1);
      end
    end
  end

  // Strobes are decoded from the next phase so they are registered outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      p_q       <= '0;
      act_q     <= 1'b0;
      mmm_clear <= 1'b0;
      mmm_ld_a  <= 1'b0;
      mmm_ld_r  <= 1'b0;
      mmm_lock  <= 1'b0;
    end else if (ena) begin
      p_q       <= p_nxt;
      act_q     <= act_nxt;
      mmm_clear <= act_nxt && (p_nxt == P_CLEAR);
      mmm_ld_a  <= act_nxt && (p_nxt == P_LD_A);
      mmm_ld_r  <= act_nxt && (p_nxt == P_LD_R);
      mmm_lock  <= act_nxt && (p_nxt == P_LOCK);
    end
  end

  assign op_last = mmm_lock;

endmodule

// File: rtl/mmm_exp_ctrl.sv
// mmm_exp_ctrl: left-to-right square-and-multiply sequencer driving a
// Montgomery multiplier.
// Build option: MMM_EXP_FINAL_CONV_EN adds a final MMM(acc,1) so result is
// in the normal domain; otherwise result stays in the Montgomery domain.
// Ports:
//   clk, rstb, ena          clock, async active-low reset, global enable
//   start                   request, taken only in IDLE with ena=1
//   base, exponent, modulus, mont_one   operands (base in Montgomery form)
//   busy, done, result      status / one-cycle done pulse / final acc
//   mmm_clear/ld_a/ld_r/lock, mmm_a/b/m, mmm_r   multiplier interface
//
// state | meaning
// IDLE  | waiting for start
// SQR   | acc = MMM(acc, acc)
// MUL   | acc = MMM(acc, base)
// CONV  | acc = MMM(acc, 1), leave Montgomery domain
// FIN   | done pulse, result valid
module mmm_exp_ctrl
  import mmm_exp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] mont_one,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mmm_clear,
  output logic             mmm_ld_a,
  output logic             mmm_ld_r,
  output logic             mmm_lock,
  output logic [WIDTH-1:0] mmm_a,
  output logic [WIDTH-1:0] mmm_b,
  output logic [WIDTH-1:0] mmm_m,
  input  logic [WIDTH-1:0] mmm_r
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    I_TOP = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

`ifdef MMM_EXP_FINAL_CONV_EN
  localparam bit HAS_CONV = 1'b1;
`else
  localparam bit HAS_CONV = 1'b0;
`endif

  exp_state_t       state;
  logic [WIDTH-1:0] acc, base_q, exp_q;
  logic [IW-1:0]    i_q;
  logic             op_last, op_start, chain_more;

  // Whether the op locking this cycle is followed by another op.
  always_comb begin
    chain_more = 1'b0;
    case (state)
      ST_SQR:  chain_more = exp_q[i_q] || (i_q != '0) || HAS_CONV;
      ST_MUL:  chain_more = (i_q != '0) || HAS_CONV;
      default: chain_more = 1'b0;
    endcase
  end

  assign op_start = ((state == ST_IDLE) && start) || (op_last && chain_more);

  mmm_phase_gen #(.WIDTH(WIDTH)) u_phase (
    .clk       (clk),
    .rstb      (rstb),
    .ena       (ena),
    .op_start  (op_start),
    .mmm_clear (mmm_clear),
    .mmm_ld_a  (mmm_ld_a),
    .mmm_ld_r  (mmm_ld_r),
    .mmm_lock  (mmm_lock),
    .op_last   (op_last)
  );

  // Operand buses are updated together with acc at each lock edge so they
  // are already valid in the clear cycle of the following op.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      mmm_a  <= '0;
      mmm_b  <= '0;
      mmm_m  <= '0;
      acc    <= '0;
      base_q <= '0;
      exp_q  <= '0;
      i_q    <= '0;
    end else if (ena) begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q <= base;
            exp_q  <= exponent;
            mmm_m  <= modulus;
            acc    <= mont_one;
            mmm_a  <= mont_one;
            mmm_b  <= mont_one;
            i_q    <= I_TOP;
            busy   <= 1'b1;
            state  <= ST_SQR;
          end
        end
        ST_SQR, ST_MUL: begin
          if (op_last) begin
            acc <= mmm_r;
            if ((state == ST_SQR) && exp_q[i_q]) begin
              mmm_a <= mmm_r;
              mmm_b <= base_q;
              state <= ST_MUL;
            end else if (i_q != '0) begin
              mmm_a <= mmm_r;
              mmm_b <= mmm_r;
              i_q   <= i_q - IW'(1);
              state <= ST_SQR;
            end else if (HAS_CONV) begin
              mmm_a <= mmm_r;
              mmm_b <= ONE;
              state <= ST_CONV;
            end else begin
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= mmm_r;
              state  <= ST_FIN;
            end
          end
        end
        ST_CONV: begin
          if (op_last) begin
            acc    <= mmm_r;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= mmm_r;
            state  <= ST_FIN;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmm_exp_ctrl.sv
module tb_mmm_exp_ctrl;

  logic       clk = 1'b0;
  logic       rstb, ena, start;
  logic [7:0] base, exponent, modulus, mont_one;
  logic       busy, done, mmm_clear, mmm_ld_a, mmm_ld_r, mmm_lock;
  logic [7:0] result, mmm_a, mmm_b, mmm_m, mmm_r;

  int checks = 0;
  int errors = 0;

`ifdef MMM_EXP_FINAL_CONV_EN
  localparam int CONV = 1;
`else
  localparam int CONV = 0;
`endif

  always #5 clk = ~clk;

  // Reduced Montgomery model, M=13, R=256, R^-1 mod 13 = 3
  assign mmm_r = 8'((int'(mmm_a) * int'(mmm_b) * 3) % 13);

  mmm_exp_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .start(start),
    .base(base), .exponent(exponent), .modulus(modulus), .mont_one(mont_one),
    .busy(busy), .done(done), .result(result),
    .mmm_clear(mmm_clear), .mmm_ld_a(mmm_ld_a), .mmm_ld_r(mmm_ld_r), .mmm_lock(mmm_lock),
    .mmm_a(mmm_a), .mmm_b(mmm_b), .mmm_m(mmm_m), .mmm_r(mmm_r)
  );

  typedef struct {
    logic [7:0] b;         // base in Montgomery form
    logic [7:0] e;
    logic [7:0] res_mont;  // P^E * R mod 13
    logic [7:0] res_norm;  // P^E mod 13
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {26'd0, busy, done, result, mmm_clear, mmm_ld_a, mmm_ld_r, mmm_lock,
            mmm_a, mmm_b, mmm_m};
  endfunction

  task automatic run_exp(input logic [7:0] b, input logic [7:0] e,
                         input int freeze_at, input int inject_at,
                         output int lat, output int nclr,
                         output logic [7:0] res, output logic busy_d);
    logic [63:0] snap;
    @(negedge clk);
    base = b; exponent = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1; nclr = 0; res = '0; busy_d = 1'b1;
    forever begin
      if (mmm_clear) nclr++;
      if (done) begin
        res = result; busy_d = busy;
        break;
      end
      if (lat >= 2000) break;
      start = (lat == inject_at);
      if (lat == freeze_at) begin
        ena  = 1'b0;
        snap = out_vec();
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          lat++;
          check("freeze_hold", out_vec(), snap);
        end
        ena = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [7:0] exp_res);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, 64'(done), 64'd1);
    check({name, "_result"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    int lat, nclr, exp_ops, dcount;
    logic [7:0] res, exp_res, exp_basic;
    logic busy_d;
    logic [3:0] strb;

    vecs[0] = '{8'd5,  8'd3,   8'd7,  8'd8};
    vecs[1] = '{8'd5,  8'd0,   8'd9,  8'd1};
    vecs[2] = '{8'd1,  8'd5,   8'd3,  8'd9};
    vecs[3] = '{8'd5,  8'd255, 8'd7,  8'd8};
    vecs[4] = '{8'd10, 8'd128, 8'd1,  8'd3};
    vecs[5] = '{8'd2,  8'd12,  8'd9,  8'd1};
    vecs[6] = '{8'd11, 8'd2,   8'd12, 8'd10};
    exp_basic = (CONV != 0) ? 8'd8 : 8'd7;

    rstb = 1'b0; ena = 1'b1; start = 1'b0;
    base = '0; exponent = '0; modulus = 8'd13; mont_one = 8'd9;
    repeat (2) @(negedge clk);
    check("reset_outputs", out_vec(), 64'd0);
    rstb = 1'b1;
    @(negedge clk);

    // Table-driven runs
    for (int v = 0; v < 7; v++) begin
      exp_res = (CONV != 0) ? vecs[v].res_norm : vecs[v].res_mont;
      exp_ops = 8 + $countones(vecs[v].e) + CONV;
      run_exp(vecs[v].b, vecs[v].e, -1, -1, lat, nclr, res, busy_d);
      check($sformatf("vec%0d_result", v), 64'(res), 64'(exp_res));
      check($sformatf("vec%0d_latency", v), 64'(lat), 64'(exp_ops * 12 + 1));
      check($sformatf("vec%0d_ops", v), 64'(nclr), 64'(exp_ops));
      check($sformatf("vec%0d_busy_at_done", v), 64'(busy_d), 64'd0);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", v), 64'(done), 64'd0);
    end

    // Strobe timing of the first op, then start held across FIN
    @(negedge clk);
    base = 8'd5; exponent = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_op_a", 64'(mmm_a), 64'd9);
    check("first_op_b", 64'(mmm_b), 64'd9);
    check("first_op_m", 64'(mmm_m), 64'd13);
    check("first_op_busy", 64'(busy), 64'd1);
    for (int c = 1; c <= 12; c++) begin
      strb = {mmm_clear, mmm_ld_a, mmm_ld_r, mmm_lock};
      check($sformatf("strobe_T+%0d", c), 64'(strb),
            64'({c == 1, c == 2, c == 11, c == 12}));
      @(negedge clk);
    end
    wait_done("fin_start", exp_basic);
    start = 1'b1;                      // present during FIN: ignored
    @(negedge clk);
    check("fin_start_ignored", 64'({busy, mmm_clear}), 64'd0);
    @(negedge clk);                    // taken in the IDLE cycle
    start = 1'b0;
    check("idle_start_taken", 64'({busy, mmm_clear}), 64'b11);
    wait_done("after_fin", exp_basic);

    // ena low for 5 cycles while ld_r is high
    run_exp(8'd5, 8'd3, 11, -1, lat, nclr, res, busy_d);
    check("freeze_result", 64'(res), 64'(exp_basic));
    check("freeze_latency", 64'(lat), 64'((10 + CONV) * 12 + 1 + 5));

    // start pulsed while busy is ignored
    run_exp(8'd5, 8'd3, -1, 40, lat, nclr, res, busy_d);
    check("inject_result", 64'(res), 64'(exp_basic));
    check("inject_latency", 64'(lat), 64'((10 + CONV) * 12 + 1));
    check("inject_ops", 64'(nclr), 64'(10 + CONV));

    // Reset mid-operation
    @(negedge clk);
    base = 8'd5; exponent = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    rstb = 1'b0;
    #1;
    check("midop_reset_outputs", out_vec(), 64'd0);
    @(negedge clk);
    rstb = 1'b1;
    dcount = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("no_activity_after_reset", 64'(dcount), 64'd0);
    run_exp(8'd5, 8'd3, -1, -1, lat, nclr, res, busy_d);
    check("post_reset_result", 64'(res), 64'(exp_basic));
    check("post_reset_latency", 64'(lat), 64'((10 + CONV) * 12 + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
